// File: rtl/issue_scheduler_pkg.sv
// Shared types and default sizing for the issue scheduler.
package issue_scheduler_pkg;

   typedef enum logic [1:0] {
      FU_ALU  = 2'd0,
      FU_MULT = 2'd1,
      FU_LD   = 2'd2,
      FU_ST   = 2'd3
   } fu_type_e;

   localparam int unsigned NUM_RS_DEF   = 8;
   localparam int unsigned NUM_ALU_DEF  = 2;
   localparam int unsigned MULT_LAT_DEF = 4;

endpackage

// File: rtl/issue_scheduler_rr_picker.sv
// Combinational rotating-priority picker: first request at or after ptr, wrapping at N.
module issue_scheduler_rr_picker #(
   parameter int unsigned N     = 8,
   parameter int unsigned IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic             gnt_valid,
   output logic [IDX_W-1:0] gnt_idx
);

   logic [IDX_W:0] pos;

   always_comb begin
      gnt       = '0;
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      pos       = '0;
      for (int unsigned i = 0; i < N; i++) begin
         pos = {1'b0, ptr} + (IDX_W+1)'(i);
         if (pos >= (IDX_W+1)'(N)) pos = pos - (IDX_W+1)'(N);
         if (!gnt_valid && req[pos[IDX_W-1:0]]) begin
            gnt_valid = 1'b1;
            gnt_idx   = pos[IDX_W-1:0];
         end
      end
      if (gnt_valid) gnt[gnt_idx] = 1'b1;
   end

endmodule

// File: rtl/issue_scheduler.sv
// Issue select between the RS and the FUs: per-class rotating pickers, registered issue
// packets, and MULT/LSU occupancy tracking.
module issue_scheduler
   import issue_scheduler_pkg::*;
#(
   parameter int unsigned NUM_RS   = NUM_RS_DEF,
   parameter int unsigned IDX_W    = $clog2(NUM_RS),
   parameter int unsigned NUM_ALU  = NUM_ALU_DEF,
   parameter int unsigned MULT_LAT = MULT_LAT_DEF
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          flush,
   input  logic [NUM_RS-1:0]             rs_ready,
   input  logic [NUM_RS-1:0][1:0]        rs_fu_type,
   output logic [NUM_RS-1:0]             rs_grant,
   output logic [NUM_ALU-1:0]            alu_issue_valid,
   output logic [NUM_ALU-1:0][IDX_W-1:0] alu_issue_idx,
   output logic                          mult_issue_valid,
   output logic [IDX_W-1:0]              mult_issue_idx,
   output logic                          lsu_issue_valid,
   output logic [IDX_W-1:0]              lsu_issue_idx,
   input  logic                          lsu_done,
   output logic                          mult_busy,
   output logic                          lsu_busy
);

   localparam int unsigned CNT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

   logic [CNT_W-1:0]              mult_cnt;
   logic [IDX_W-1:0]              alu_ptr, mult_ptr, lsu_ptr;
   logic [NUM_RS-1:0]             cand_alu, cand_mult, cand_lsu;
   logic [NUM_ALU-1:0]            alu_valid;
   logic [NUM_ALU-1:0][IDX_W-1:0] alu_idx;
   logic [IDX_W-1:0]              alu_last;
   logic [NUM_RS-1:0]             mult_gnt, lsu_gnt;
   logic                          mult_valid, lsu_valid;
   logic [IDX_W-1:0]              mult_idx, lsu_idx;

   function automatic logic [IDX_W-1:0] inc_ptr(input logic [IDX_W-1:0] idx);
      return (idx == IDX_W'(NUM_RS - 1)) ? '0 : idx + IDX_W'(1);
   endfunction

   always_comb begin
      cand_alu  = '0;
      cand_mult = '0;
      cand_lsu  = '0;
      for (int unsigned i = 0; i < NUM_RS; i++) begin
         cand_alu[i]  = rs_ready[i] && (rs_fu_type[i] == FU_ALU);
         cand_mult[i] = rs_ready[i] && (rs_fu_type[i] == FU_MULT) && (mult_cnt == '0);
         cand_lsu[i]  = rs_ready[i] && ((rs_fu_type[i] == FU_LD) || (rs_fu_type[i] == FU_ST))
                        && (!lsu_busy || lsu_done);
      end
   end

   // Each ALU picker sees the candidates left over by the pickers before it.
   for (genvar k = 0; k < NUM_ALU; k++) begin : g_alu
      logic [NUM_RS-1:0] req, gnt, acc;
      if (k == 0) begin : g_first
         assign req = cand_alu;
         assign acc = gnt;
      end else begin : g_next
         assign req = g_alu[k-1].req & ~g_alu[k-1].gnt;
         assign acc = g_alu[k-1].acc | gnt;
      end
      issue_scheduler_rr_picker #(.N(NUM_RS), .IDX_W(IDX_W)) u_alu_pick (
         .req       (req),
         .ptr       (alu_ptr),
         .gnt       (gnt),
         .gnt_valid (alu_valid[k]),
         .gnt_idx   (alu_idx[k])
      );
   end

   issue_scheduler_rr_picker #(.N(NUM_RS), .IDX_W(IDX_W)) u_mult_pick (
      .req       (cand_mult),
      .ptr       (mult_ptr),
      .gnt       (mult_gnt),
      .gnt_valid (mult_valid),
      .gnt_idx   (mult_idx)
   );

   issue_scheduler_rr_picker #(.N(NUM_RS), .IDX_W(IDX_W)) u_lsu_pick (
      .req       (cand_lsu),
      .ptr       (lsu_ptr),
      .gnt       (lsu_gnt),
      .gnt_valid (lsu_valid),
      .gnt_idx   (lsu_idx)
   );

   always_comb begin
      alu_last = alu_idx[0];
      for (int unsigned k = 0; k < NUM_ALU; k++) begin
         if (alu_valid[k]) alu_last = alu_idx[k];
      end
      rs_grant = '0;
      if (reset && !flush) rs_grant = g_alu[NUM_ALU-1].acc | mult_gnt | lsu_gnt;
   end

   assign mult_busy = (mult_cnt != '0);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         alu_issue_valid  <= '0;
         alu_issue_idx    <= '0;
         mult_issue_valid <= 1'b0;
         mult_issue_idx   <= '0;
         lsu_issue_valid  <= 1'b0;
         lsu_issue_idx    <= '0;
         alu_ptr          <= '0;
         mult_ptr         <= '0;
         lsu_ptr          <= '0;
         mult_cnt         <= '0;
         lsu_busy         <= 1'b0;
      end else begin
         for (int unsigned k = 0; k < NUM_ALU; k++) begin
            alu_issue_valid[k] <= alu_valid[k] && !flush;
            if (alu_valid[k]) alu_issue_idx[k] <= alu_idx[k];
         end
         mult_issue_valid <= mult_valid && !flush;
         lsu_issue_valid  <= lsu_valid && !flush;
         if (mult_valid) mult_issue_idx <= mult_idx;
         if (lsu_valid)  lsu_issue_idx  <= lsu_idx;

         if (!flush && alu_valid[0]) alu_ptr  <= inc_ptr(alu_last);
         if (!flush && mult_valid)   mult_ptr <= inc_ptr(mult_idx);
         if (!flush && lsu_valid)    lsu_ptr  <= inc_ptr(lsu_idx);

         if (flush)                 mult_cnt <= '0;
         else if (mult_valid)       mult_cnt <= CNT_W'(MULT_LAT - 1);
         else if (mult_cnt != '0)   mult_cnt <= mult_cnt - CNT_W'(1);

         // A memory op in flight cannot be squashed, so flush leaves lsu_busy alone.
         if (!flush && lsu_valid)   lsu_busy <= 1'b1;
         else if (lsu_done)         lsu_busy <= 1'b0;
      end
   end

endmodule

// File: tb/tb_issue_scheduler.sv
// Self-checking bench for issue_scheduler: directed table plus randomized traffic vs a model.
module tb_issue_scheduler;

   localparam int NRS  = 8;
   localparam int MLAT = 4;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic            flush = 1'b0;
   logic            lsu_done = 1'b0;
   logic [7:0]      rs_ready = '0;
   logic [7:0][1:0] rs_fu_type = '0;
   logic [7:0]      rs_grant;
   logic [1:0]      alu_issue_valid;
   logic [1:0][2:0] alu_issue_idx;
   logic            mult_issue_valid, lsu_issue_valid;
   logic [2:0]      mult_issue_idx, lsu_issue_idx;
   logic            mult_busy, lsu_busy;

   issue_scheduler #(.NUM_RS(8), .IDX_W(3), .NUM_ALU(2), .MULT_LAT(MLAT)) dut (
      .clock            (clock),
      .reset            (reset),
      .flush            (flush),
      .rs_ready         (rs_ready),
      .rs_fu_type       (rs_fu_type),
      .rs_grant         (rs_grant),
      .alu_issue_valid  (alu_issue_valid),
      .alu_issue_idx    (alu_issue_idx),
      .mult_issue_valid (mult_issue_valid),
      .mult_issue_idx   (mult_issue_idx),
      .lsu_issue_valid  (lsu_issue_valid),
      .lsu_issue_idx    (lsu_issue_idx),
      .lsu_done         (lsu_done),
      .mult_busy        (mult_busy),
      .lsu_busy         (lsu_busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [7:0]  rdy;
      logic [15:0] ty;
      bit          fl;
      bit          dn;
      logic [7:0]  gnt;
   } vec_t;

   vec_t tbl[$];
   int   n_cmp, n_bad;

   // Reference model: pointers as plain ints, MULT occupancy as cycle arithmetic.
   int p_alu, p_mult, p_lsu, cyc, last_mult;
   bit m_lsu_busy;
   bit e_alu_v[2];
   int e_alu_i[2];
   bit e_mult_v, e_lsu_v;
   int e_mult_i, e_lsu_i;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      p_alu = 0; p_mult = 0; p_lsu = 0; cyc = 0; last_mult = -1000;
      m_lsu_busy = 0; e_mult_v = 0; e_lsu_v = 0; e_mult_i = 0; e_lsu_i = 0;
      for (int k = 0; k < 2; k++) begin
         e_alu_v[k] = 0;
         e_alu_i[k] = 0;
      end
   endtask

   task automatic add(input logic [7:0] rdy, input logic [15:0] ty, input bit fl, input bit dn,
                      input logic [7:0] gnt);
      vec_t v;
      v.rdy = rdy; v.ty = ty; v.fl = fl; v.dn = dn; v.gnt = gnt;
      tbl.push_back(v);
   endtask

   // Called at posedge+1; drives inputs, checks at the falling edge, advances model at posedge.
   task automatic cycle(input logic [7:0] rdy, input logic [15:0] ty, input bit fl, input bit dn,
                        input bit has_exp, input logic [7:0] exp_gnt);
      int ap[$];
      int mp, lp;
      logic [7:0] g;
      logic [7:0][1:0] tv;
      tv = ty;
      rs_ready = rdy; rs_fu_type = tv; flush = fl; lsu_done = dn;
      mp = -1; lp = -1; g = '0;
      if (!fl) begin
         for (int s = 0; s < NRS; s++) begin
            int e;
            e = (p_alu + s) % NRS;
            if (rdy[e] && tv[e] == 2'd0 && ap.size() < 2) ap.push_back(e);
         end
         if (cyc - last_mult >= MLAT) begin
            for (int s = 0; s < NRS; s++) begin
               int e;
               e = (p_mult + s) % NRS;
               if (mp < 0 && rdy[e] && tv[e] == 2'd1) mp = e;
            end
         end
         if (!m_lsu_busy || dn) begin
            for (int s = 0; s < NRS; s++) begin
               int e;
               e = (p_lsu + s) % NRS;
               if (lp < 0 && rdy[e] && tv[e] >= 2'd2) lp = e;
            end
         end
      end
      foreach (ap[i]) g[ap[i]] = 1'b1;
      if (mp >= 0) g[mp] = 1'b1;
      if (lp >= 0) g[lp] = 1'b1;
      #4;
      chk("rs_grant", 32'(rs_grant), 32'(g));
      if (has_exp) chk("table_grant", 32'(rs_grant), 32'(exp_gnt));
      for (int k = 0; k < 2; k++) begin
         chk("alu_valid", 32'(alu_issue_valid[k]), 32'(e_alu_v[k]));
         if (e_alu_v[k]) chk("alu_idx", 32'(alu_issue_idx[k]), 32'(e_alu_i[k]));
      end
      chk("mult_valid", 32'(mult_issue_valid), 32'(e_mult_v));
      if (e_mult_v) chk("mult_idx", 32'(mult_issue_idx), 32'(e_mult_i));
      chk("lsu_valid", 32'(lsu_issue_valid), 32'(e_lsu_v));
      if (e_lsu_v) chk("lsu_idx", 32'(lsu_issue_idx), 32'(e_lsu_i));
      chk("mult_busy", 32'(mult_busy), 32'((cyc > last_mult) && (cyc - last_mult < MLAT)));
      chk("lsu_busy", 32'(lsu_busy), 32'(m_lsu_busy));
      @(posedge clock);
      for (int k = 0; k < 2; k++) begin
         e_alu_v[k] = (k < ap.size());
         e_alu_i[k] = (k < ap.size()) ? ap[k] : 0;
      end
      if (ap.size() > 0) p_alu = (ap[ap.size()-1] + 1) % NRS;
      e_mult_v = (mp >= 0); e_mult_i = (mp >= 0) ? mp : 0;
      e_lsu_v  = (lp >= 0); e_lsu_i  = (lp >= 0) ? lp : 0;
      if (mp >= 0) p_mult = (mp + 1) % NRS;
      if (lp >= 0) p_lsu = (lp + 1) % NRS;
      if (fl) last_mult = -1000;
      else if (mp >= 0) last_mult = cyc;
      if (lp >= 0) m_lsu_busy = 1;
      else if (dn) m_lsu_busy = 0;
      cyc++;
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      n_cmp = 0; n_bad = 0;
      model_reset();
      rs_ready = 8'hFF;
      #12;
      chk("reset_grant", 32'(rs_grant), 32'h0);
      chk("reset_alu_valid", 32'(alu_issue_valid), 32'h0);
      chk("reset_busy", 32'({mult_busy, lsu_busy, mult_issue_valid, lsu_issue_valid}), 32'h0);
      rs_ready = '0;
      reset = 1'b1;
      @(posedge clock);
      #1;

      for (int i = 0; i < 5; i++) add(8'h00, 16'h0000, 0, 0, 8'h00);
      add(8'h0F, 16'h0000, 0, 0, 8'h03);
      add(8'h0C, 16'h0000, 0, 0, 8'h0C);
      add(8'h20, 16'h0000, 0, 0, 8'h20);
      add(8'hC1, 16'h0000, 0, 0, 8'hC0);
      add(8'h01, 16'h0000, 0, 0, 8'h01);
      add(8'h24, 16'h0410, 0, 0, 8'h04);
      for (int i = 0; i < 3; i++) add(8'h20, 16'h0410, 0, 0, 8'h00);
      add(8'h20, 16'h0410, 0, 0, 8'h20);
      add(8'h00, 16'h0410, 0, 0, 8'h00);
      add(8'h18, 16'h0380, 0, 0, 8'h08);
      add(8'h10, 16'h0380, 0, 0, 8'h00);
      add(8'h10, 16'h0380, 0, 0, 8'h00);
      add(8'h10, 16'h0380, 0, 1, 8'h10);
      add(8'h00, 16'h0380, 0, 0, 8'h00);
      add(8'h00, 16'h0000, 0, 1, 8'h00);
      add(8'h00, 16'h0000, 0, 0, 8'h00);
      add(8'h0A, 16'h0084, 0, 0, 8'h0A);
      add(8'h21, 16'h0400, 1, 0, 8'h00);
      add(8'h21, 16'h0400, 0, 0, 8'h21);
      add(8'h00, 16'h0000, 0, 1, 8'h00);
      add(8'h00, 16'h0000, 0, 0, 8'h00);
      foreach (tbl[i]) cycle(tbl[i].rdy, tbl[i].ty, tbl[i].fl, tbl[i].dn, 1'b1, tbl[i].gnt);

      for (int i = 0; i < 300; i++) begin
         cycle(8'($urandom), 16'($urandom), ($urandom_range(15) == 0), ($urandom_range(3) == 0),
               1'b0, 8'h00);
      end

      // Reset in the middle of a MULT occupancy window.
      for (int i = 0; i < 5; i++) cycle(8'h00, 16'h0000, 0, 0, 1'b1, 8'h00);
      cycle(8'h04, 16'h0010, 0, 0, 1'b1, 8'h04);
      rs_ready = 8'h04;
      #1;
      chk("mult_busy_before_reset", 32'(mult_busy), 32'h1);
      #1 reset = 1'b0;
      #1;
      chk("mult_busy_async_drop", 32'(mult_busy), 32'h0);
      chk("grant_in_reset", 32'(rs_grant), 32'h0);
      chk("mult_valid_in_reset", 32'(mult_issue_valid), 32'h0);
      rs_ready = '0;
      @(posedge clock);
      #1;
      chk("alu_valid_in_reset", 32'(alu_issue_valid), 32'h0);
      #3 reset = 1'b1;
      @(posedge clock);
      #1;
      model_reset();
      cycle(8'h00, 16'h0000, 0, 0, 1'b1, 8'h00);
      cycle(8'h0F, 16'h0000, 0, 0, 1'b1, 8'h03);
      cycle(8'h00, 16'h0000, 0, 0, 1'b1, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
